// File: rtl/pb_step_ctrl.sv
// Per-channel pushbutton synchroniser, debouncer and one-shot step pulser; PB_AUTOREPEAT_EN adds hold-to-repeat.
// Latency: clkEn pulses in the cycle after edge k+2+DEBOUNCE_CYCLES when a press is first sampled at edge k.
// Backpressure: none; buttons are sampled every cycle and pulses are never held off.
module pb_step_ctrl #(
    parameter int N_CH            = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 20,
    parameter int REPEAT_PERIOD   = 8,
    parameter int CNT_W           = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CH-1:0]       clkPB,
    output logic [N_CH-1:0]       clkEn,
    output logic [N_CH-1:0]       pressed,
    output logic [N_CH*CNT_W-1:0] pulseCnt
);

    typedef enum logic [1:0] {IDLE, ARM, HELD, REL} state_t;

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);

`ifdef PB_AUTOREPEAT_EN
    localparam int TW = $clog2(REPEAT_DELAY + 1);
    localparam int PW = $clog2(REPEAT_PERIOD);
    localparam logic [TW-1:0] T_FIRST = TW'(REPEAT_DELAY);
    localparam logic [TW-1:0] T_PRE   = TW'(REPEAT_DELAY - 1);
    localparam logic [PW-1:0] P_LAST  = PW'(REPEAT_PERIOD - 1);
`endif

    if (N_CH < 1 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 2 || CNT_W < 1) begin : g_bad_cfg
        $error("pb_step_ctrl: illegal parameter value");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic             sync1;
        logic             s;
        state_t           st;
        logic [DW-1:0]    dcnt;
        logic             en;
        logic             prs;
        logic [CNT_W-1:0] cnt;
`ifdef PB_AUTOREPEAT_EN
        // t saturates at REPEAT_DELAY; p then paces the periodic pulses
        logic [TW-1:0]    t;
        logic [PW-1:0]    p;
`endif

        always_ff @(posedge clk) begin
            if (reset) begin
                sync1 <= 1'b0;
                s     <= 1'b0;
                st    <= IDLE;
                dcnt  <= '0;
                en    <= 1'b0;
                prs   <= 1'b0;
                cnt   <= '0;
`ifdef PB_AUTOREPEAT_EN
                t     <= '0;
                p     <= '0;
`endif
            end else begin
                sync1 <= clkPB[i];
                s     <= sync1;
                en    <= 1'b0;
                cnt   <= cnt + CNT_W'(en);
                case (st)
                    IDLE: begin
                        if (s) begin
                            st   <= ARM;
                            dcnt <= '0;
                        end
                    end
                    ARM: begin
                        if (!s) begin
                            st <= IDLE;
                        end else if (dcnt == DLAST) begin
                            st  <= HELD;
                            en  <= 1'b1;
                            prs <= 1'b1;
`ifdef PB_AUTOREPEAT_EN
                            t   <= '0;
                            p   <= '0;
`endif
                        end else begin
                            dcnt <= dcnt + DW'(1);
                        end
                    end
                    HELD: begin
                        if (!s) begin
                            st   <= REL;
                            dcnt <= '0;
                        end else begin
`ifdef PB_AUTOREPEAT_EN
                            if (t != T_FIRST) begin
                                t <= t + TW'(1);
                                if (t == T_PRE) en <= 1'b1;
                            end else if (p == P_LAST) begin
                                p  <= '0;
                                en <= 1'b1;
                            end else begin
                                p <= p + PW'(1);
                            end
`endif
                        end
                    end
                    REL: begin
                        // a bounce back to 1 resumes the hold without a new pulse
                        if (s) begin
                            st <= HELD;
`ifdef PB_AUTOREPEAT_EN
                            t  <= '0;
                            p  <= '0;
`endif
                        end else if (dcnt == DLAST) begin
                            st  <= IDLE;
                            prs <= 1'b0;
                        end else begin
                            dcnt <= dcnt + DW'(1);
                        end
                    end
                    default: st <= IDLE;
                endcase
            end
        end

        assign clkEn[i]                    = en;
        assign pressed[i]                  = prs;
        assign pulseCnt[i*CNT_W +: CNT_W]  = cnt;
    end

endmodule

// File: tb/tb_pb_step_ctrl.sv
// Scoreboarded bench for pb_step_ctrl: directed scenarios plus random bouncing buttons against a level-hysteresis model.
// Latency: outputs compared in the cycle the model predicts. Backpressure: none.
module tb_pb_step_ctrl;

    localparam int N  = 2;
    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 8;
    localparam int CW = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    clkPB = '0;
    logic [N-1:0]    clkEn;
    logic [N-1:0]    pressed;
    logic [N*CW-1:0] pulseCnt;

    pb_step_ctrl #(
        .N_CH(N), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .clkPB(clkPB),
        .clkEn(clkEn), .pressed(pressed), .pulseCnt(pulseCnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input bit ok, input longint act, input longint exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        int              cyc;
        logic [N-1:0]    en;
        logic [N-1:0]    prs;
        logic [N*CW-1:0] cnt;
    } exp_t;
    exp_t q[$];

    // Model: debounced level flips after D+1 consecutive synchronised samples disagreeing with it.
    int sync_m[N], s_m[N], lvl[N], opp[N], en_m[N], cnt_m[N], t_m[N];
    logic [N-1:0] prs_last = '0;

    task automatic model_step(input logic [N-1:0] pb, input logic rst);
        exp_t e;
        int   sf;
        for (int ch = 0; ch < N; ch++) begin
            if (rst) begin
                sync_m[ch] = 0; s_m[ch] = 0; lvl[ch] = 0; opp[ch] = 0;
                en_m[ch] = 0; cnt_m[ch] = 0; t_m[ch] = 0;
            end else begin
                cnt_m[ch] = (cnt_m[ch] + en_m[ch]) % (1 << CW);
                sf = s_m[ch];
                s_m[ch] = sync_m[ch];
                sync_m[ch] = int'(pb[ch]);
                en_m[ch] = 0;
                if (lvl[ch] == 0) begin
                    if (sf != 0) begin
                        opp[ch]++;
                        if (opp[ch] == D + 1) begin
                            lvl[ch] = 1; opp[ch] = 0; en_m[ch] = 1; t_m[ch] = 0;
                        end
                    end else begin
                        opp[ch] = 0;
                    end
                end else if (sf == 0) begin
                    opp[ch]++;
                    if (opp[ch] == D + 1) begin
                        lvl[ch] = 0; opp[ch] = 0;
                    end
                end else if (opp[ch] > 0) begin
                    opp[ch] = 0; t_m[ch] = 0;
                end else begin
                    t_m[ch]++;
`ifdef PB_AUTOREPEAT_EN
                    if (t_m[ch] == RD || (t_m[ch] > RD && (t_m[ch] - RD) % RP == 0)) en_m[ch] = 1;
`endif
                end
            end
            e.en[ch]           = (en_m[ch] != 0);
            e.prs[ch]          = (lvl[ch] != 0);
            e.cnt[ch*CW +: CW] = CW'(cnt_m[ch]);
        end
        e.cyc = cyc + 1;
        if (e.en != '0 || e.prs != prs_last) q.push_back(e);
        prs_last = e.prs;
    endtask

    task automatic step(input logic [N-1:0] pb, input logic rst);
        clkPB = pb;
        reset = rst;
        model_step(pb, rst);
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [N-1:0] pb, input int n);
        repeat (n) step(pb, 1'b0);
    endtask

    // Monitor: every output event from the DUT pops one scoreboard entry.
    int   npulse[N];
    int   last_pulse[N];
    bit   both_seen = 0;
    bit   prs0_seen = 0;
    logic [N-1:0] prev_prs = '0;
    exp_t got;

    always @(negedge clk) begin
        if (cyc > 0) begin
            for (int ch = 0; ch < N; ch++) begin
                if (clkEn[ch]) begin
                    npulse[ch]++;
                    last_pulse[ch] = cyc;
                end
            end
            if (clkEn == '1) both_seen = 1;
            if (pressed[0]) prs0_seen = 1;
            if (clkEn != '0 || pressed != prev_prs) begin
                check("event_expected", q.size() != 0, longint'(clkEn), 0);
                if (q.size() != 0) begin
                    got = q.pop_front();
                    check("event_cycle", cyc == got.cyc, cyc, got.cyc);
                    check("clkEn", clkEn == got.en, clkEn, got.en);
                    check("pressed", pressed == got.prs, pressed, got.prs);
                    check("pulseCnt", pulseCnt == got.cnt, pulseCnt, got.cnt);
                end
            end
            prev_prs = pressed;
            while (q.size() != 0 && q[0].cyc < cyc) begin
                checks++;
                $display("FAIL missing_event: got none, expected clkEn=%0d pressed=%0d at cycle %0d (now %0d)",
                         q[0].en, q[0].prs, q[0].cyc, cyc);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "watchdog");
    end

    int   k, n0, n1;
    logic [CW-1:0] cnt_seq [5];
    logic [N-1:0]  pb;
    logic [N-1:0]  flip;
    int   len;

    initial begin
        cnt_seq[0] = 2'd1; cnt_seq[1] = 2'd2; cnt_seq[2] = 2'd3; cnt_seq[3] = 2'd0; cnt_seq[4] = 2'd1;

        step('0, 1'b1);
        step('0, 1'b1);
        check("reset_clkEn", clkEn == '0, clkEn, 0);
        check("reset_pressed", pressed == '0, pressed, 0);
        check("reset_pulseCnt", pulseCnt == '0, pulseCnt, 0);
        hold('0, 3);

        // single press on channel 0
        k = cyc + 1;
        n0 = npulse[0]; n1 = npulse[1];
        hold(2'b01, 10);
        hold(2'b00, 20);
        check("press_latency", last_pulse[0] - k == 6, last_pulse[0] - k, 6);
        check("press_pulses_ch0", npulse[0] - n0 == 1, npulse[0] - n0, 1);
        check("press_pulses_ch1", npulse[1] - n1 == 0, npulse[1] - n1, 0);
        check("press_cnt", pulseCnt == 4'b0001, pulseCnt, 1);

        // short glitch
        n0 = npulse[0]; prs0_seen = 0;
        hold(2'b01, 3);
        hold(2'b00, 10);
        check("glitch_pulses", npulse[0] - n0 == 0, npulse[0] - n0, 0);
        check("glitch_pressed", prs0_seen == 0, prs0_seen, 0);

        // release bounce
        n0 = npulse[0];
        hold(2'b01, 10);
        hold(2'b00, 2);
        hold(2'b01, 5);
        hold(2'b00, 20);
        check("bounce_pulses", npulse[0] - n0 == 1, npulse[0] - n0, 1);

        // simultaneous press
        step('0, 1'b1);
        both_seen = 0;
        hold(2'b11, 10);
        hold(2'b00, 20);
        check("simul_same_cycle", both_seen == 1, both_seen, 1);
        check("simul_cnt", pulseCnt == 4'b0101, pulseCnt, 5);

        // long hold
        n0 = npulse[0];
        hold(2'b01, 60);
        hold(2'b00, 20);
`ifdef PB_AUTOREPEAT_EN
        check("hold60_pulses", npulse[0] - n0 == 6, npulse[0] - n0, 6);
`else
        check("hold60_pulses", npulse[0] - n0 == 1, npulse[0] - n0, 1);
`endif

        // reset while held
        hold(2'b01, 15);
        step(2'b01, 1'b1);
        k = cyc;
        check("midreset_clkEn", clkEn == '0, clkEn, 0);
        check("midreset_pressed", pressed == '0, pressed, 0);
        check("midreset_cnt", pulseCnt == '0, pulseCnt, 0);
        n0 = npulse[0];
        hold(2'b01, 20);
        hold(2'b00, 20);
        check("midreset_pulses", npulse[0] - n0 == 1, npulse[0] - n0, 1);
        check("midreset_latency", last_pulse[0] - (k + 1) == 6, last_pulse[0] - (k + 1), 6);

        // counter wrap
        step('0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            hold(2'b01, 8);
            hold(2'b00, 12);
            check("wrap_cnt", pulseCnt[CW-1:0] == cnt_seq[i], pulseCnt[CW-1:0], cnt_seq[i]);
        end

        // random bouncing buttons with occasional resets
        for (int seg = 0; seg < 200; seg++) begin
            pb = N'($urandom_range(0, 3));
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, D) : $urandom_range(D + 1, 35);
            if ($urandom_range(0, 39) == 0) begin
                step(pb, 1'b1);
            end else begin
                for (int c = 0; c < len; c++) begin
                    flip = ($urandom_range(0, 9) == 0) ? N'($urandom_range(1, 3)) : '0;
                    step(pb ^ flip, 1'b0);
                end
            end
        end

        hold('0, 40);
        check("scoreboard_drained", q.size() == 0, q.size(), 0);
        check("final_cnt_ch0", pulseCnt[CW-1:0] == CW'(cnt_m[0]), pulseCnt[CW-1:0], cnt_m[0]);
        check("final_cnt_ch1", pulseCnt[2*CW-1:CW] == CW'(cnt_m[1]), pulseCnt[2*CW-1:CW], cnt_m[1]);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
